// File: rtl/var_bw_acc_pkg.sv
// Shared types and sum-bus field layout for the variable bit-width frame accumulator.
package var_bw_acc_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StHold
  } state_e;

  // Adder sum bus layout: parallel mode {hi[8:0], lo[8:0]}, full mode {1'b0, sum[16:0]}.
  localparam int unsigned SumW    = 18;
  localparam int unsigned LoLsb   = 0;
  localparam int unsigned LoMsb   = 8;
  localparam int unsigned HiLsb   = 9;
  localparam int unsigned HiMsb   = 17;
  localparam int unsigned FullMsb = 16;

  function automatic int unsigned lane_w(input int unsigned acc_w);
    return acc_w / 2;
  endfunction

endpackage

// File: rtl/var_bw_acc_if.sv
// Beat input and frame-result output bundle between the adder side and the result consumer.
interface var_bw_acc_if #(
  parameter int unsigned ACC_W = 24,
  parameter int unsigned CNT_W = 8
);

  logic                              in_valid;
  logic                              in_ready;
  logic                              in_para_mode;
  logic [var_bw_acc_pkg::SumW-1:0]   in_p;
  logic                              in_last;
  logic                              out_valid;
  logic                              out_ready;
  logic                              out_para_mode;
  logic [ACC_W-1:0]                  out_acc;
  logic [1:0]                        out_ovf;
  logic                              out_err;
  logic [CNT_W-1:0]                  out_count;

  modport master (
    output in_valid, in_para_mode, in_p, in_last, out_ready,
    input  in_ready, out_valid, out_para_mode, out_acc, out_ovf, out_err, out_count
  );

  modport slave (
    input  in_valid, in_para_mode, in_p, in_last, out_ready,
    output in_ready, out_valid, out_para_mode, out_acc, out_ovf, out_err, out_count
  );

endinterface

// File: rtl/var_bw_acc_lane.sv
// One accumulator lane: register plus adder with carry chaining and a sticky overflow flag.
module var_bw_acc_lane #(
  parameter int unsigned Width = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             add_en,
  input  logic [Width-1:0] addend,
  input  logic             carry_in,
  output logic [Width-1:0] acc,
  output logic             carry_out,
  output logic             ovf
);

  logic [Width-1:0] acc_q;
  logic             ovf_q;
  logic [Width:0]   sum;

  // A load adds onto zero so the lo-lane carry into the hi lane stays correct on first beats.
  always_comb begin
    sum = {1'b0, (load ? '0 : acc_q)} + {1'b0, addend} + (Width + 1)'(carry_in);
  end

  assign carry_out = sum[Width];
  assign acc       = acc_q;
  assign ovf       = ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else if (load) begin
      acc_q <= sum[Width-1:0];
      ovf_q <= sum[Width];
    end else if (add_en) begin
      acc_q <= sum[Width-1:0];
      ovf_q <= ovf_q | sum[Width];
    end
  end

endmodule

// File: rtl/var_bw_acc.sv
// Frame accumulator: sums a frame of adder beats as one wide value or two independent lanes.
module var_bw_acc
  import var_bw_acc_pkg::*;
#(
  parameter int unsigned ACC_W = 24,
  parameter int unsigned CNT_W = 8
) (
  input logic         clk,
  input logic         rst_n,
  var_bw_acc_if.slave bus
);

  localparam int unsigned LaneW = lane_w(ACC_W);

  state_e           state_q, state_d;
  logic             mode_q, mode_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             ready;
  logic             accept;
  logic             start;
  logic             add;
  logic             sel_para;

  logic [ACC_W-1:0] full_addend;
  logic [LaneW-1:0] lo_addend, hi_addend;
  logic [LaneW-1:0] lo_acc, hi_acc;
  logic             lo_cout, hi_cout, hi_cin;
  logic             lo_ovf, hi_ovf;

  assign accept = bus.in_valid & ready;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    err_d   = err_q;
    count_d = count_q;
    ready   = 1'b1;
    start   = 1'b0;
    add     = 1'b0;
    case (state_q)
      StIdle: begin
        start = accept;
      end
      StAccum: begin
        if (accept) begin
          count_d = (count_q == '1) ? count_q : count_q + CNT_W'(1);
          // Mode-mismatched beats are counted and flagged but contribute no data.
          if (bus.in_para_mode != mode_q) begin
            err_d = 1'b1;
          end else begin
            add = 1'b1;
          end
          if (bus.in_last) begin
            state_d = StHold;
          end
        end
      end
      StHold: begin
        ready = bus.out_ready;
        if (bus.out_ready) begin
          if (accept) begin
            start = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    if (start) begin
      mode_d  = bus.in_para_mode;
      count_d = CNT_W'(1);
      err_d   = 1'b0;
      state_d = bus.in_last ? StHold : StAccum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      mode_q  <= 1'b0;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
      count_q <= count_d;
    end
  end

  // A frame-starting beat takes its own mode; later beats follow the latched frame mode.
  assign sel_para    = start ? bus.in_para_mode : mode_q;
  assign full_addend = ACC_W'(bus.in_p[FullMsb:0]);

  always_comb begin
    if (sel_para) begin
      lo_addend = LaneW'(bus.in_p[LoMsb:LoLsb]);
      hi_addend = LaneW'(bus.in_p[HiMsb:HiLsb]);
      hi_cin    = 1'b0;
    end else begin
      lo_addend = full_addend[LaneW-1:0];
      hi_addend = full_addend[ACC_W-1:LaneW];
      hi_cin    = lo_cout;
    end
  end

  var_bw_acc_lane #(
    .Width (LaneW)
  ) u_lo_lane (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (start),
    .add_en    (add),
    .addend    (lo_addend),
    .carry_in  (1'b0),
    .acc       (lo_acc),
    .carry_out (lo_cout),
    .ovf       (lo_ovf)
  );

  var_bw_acc_lane #(
    .Width (LaneW)
  ) u_hi_lane (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (start),
    .add_en    (add),
    .addend    (hi_addend),
    .carry_in  (hi_cin),
    .acc       (hi_acc),
    .carry_out (hi_cout),
    .ovf       (hi_ovf)
  );

  // hi_cout is consumed through the lane's own sticky flag.
  logic unused_hi_cout;
  assign unused_hi_cout = hi_cout;

  assign bus.in_ready      = ready;
  assign bus.out_valid     = (state_q == StHold);
  assign bus.out_para_mode = mode_q;
  assign bus.out_acc       = {hi_acc, lo_acc};
  // In full mode the carry out of the whole sum is the hi lane's carry.
  assign bus.out_ovf       = mode_q ? {hi_ovf, lo_ovf} : {1'b0, hi_ovf};
  assign bus.out_err       = err_q;
  assign bus.out_count     = count_q;

endmodule
